// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 datapath types and default widths
package rc4_pkg;

  localparam int RC4_ADDR_W = 8;
  localparam int RC4_DATA_W = 8;
  localparam int RC4_KEY_W  = 24;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_INIT = 3'd1,
    PH_KSA  = 3'd2,
    PH_PRGA = 3'd3,
    PH_DONE = 3'd4,
    PH_ERR  = 3'd5
  } phase_t;

endpackage

// File: rtl/rc4_phase_ctrl_if.sv
// rtl/rc4_phase_ctrl_if.sv - controller-to-engine/memory signal bundle
interface rc4_phase_ctrl_if
  import rc4_pkg::*;
#(
  parameter int ADDR_W = RC4_ADDR_W,
  parameter int DATA_W = RC4_DATA_W,
  parameter int KEY_W  = RC4_KEY_W
) ();

  logic              start;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  key_q;

  logic              init_start;
  logic              ksa_start;
  logic              prga_start;
  logic              init_finished;
  logic              ksa_finished;
  logic              prga_finished;

  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] ksa_addr;
  logic [ADDR_W-1:0] prga_addr;
  logic [DATA_W-1:0] init_wdata;
  logic [DATA_W-1:0] ksa_wdata;
  logic [DATA_W-1:0] prga_wdata;
  logic              init_we;
  logic              ksa_we;
  logic              prga_we;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  logic [2:0]        phase;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, key,
    input  init_finished, ksa_finished, prga_finished,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wdata, ksa_wdata, prga_wdata,
    input  init_we, ksa_we, prga_we,
    output key_q, init_start, ksa_start, prga_start,
    output mem_addr, mem_wdata, mem_we,
    output phase, busy, done, error
  );

  modport slave (
    output start, key,
    output init_finished, ksa_finished, prga_finished,
    output init_addr, ksa_addr, prga_addr,
    output init_wdata, ksa_wdata, prga_wdata,
    output init_we, ksa_we, prga_we,
    input  key_q, init_start, ksa_start, prga_start,
    input  mem_addr, mem_wdata, mem_we,
    input  phase, busy, done, error
  );

endinterface

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector with re-arm on phase entry
module rise_detect (
  input  logic clk,
  input  logic clr,
  input  logic arm,
  input  logic en,
  input  logic d,
  output logic rise
);

  logic prev;

  // On arm the history is cleared and reloaded with the live level, so a level
  // left high by an earlier run counts as already seen rather than as an edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev <= 1'b0;
    end else if (arm || en) begin
      prev <= d;
    end
  end

  assign rise = en & d & ~prev;

endmodule

// File: rtl/rc4_phase_ctrl.sv
// rtl/rc4_phase_ctrl.sv - RC4 phase sequencer and S-memory port arbiter
module rc4_phase_ctrl
  import rc4_pkg::*;
#(
  parameter int ADDR_W  = RC4_ADDR_W,
  parameter int DATA_W  = RC4_DATA_W,
  parameter int KEY_W   = RC4_KEY_W,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             clr,
  rc4_phase_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'(PH_IDLE);
  localparam logic [2:0] S_INIT = 3'(PH_INIT);
  localparam logic [2:0] S_KSA  = 3'(PH_KSA);
  localparam logic [2:0] S_PRGA = 3'(PH_PRGA);
  localparam logic [2:0] S_DONE = 3'(PH_DONE);
  localparam logic [2:0] S_ERR  = 3'(PH_ERR);

  // Counter only needs to reach TIMEOUT-1.
  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              idle_like;
  logic              accept;
  logic              busy_w;
  logic              wd_expired;
  logic [WD_W-1:0]   wd_cnt;
  logic [KEY_W-1:0]  key_r;

  logic              enter_init;
  logic              enter_ksa;
  logic              enter_prga;
  logic              init_rise;
  logic              ksa_rise;
  logic              prga_rise;

  logic              init_start_r;
  logic              ksa_start_r;
  logic              prga_start_r;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign busy_w     = (state == S_INIT) || (state == S_KSA) || (state == S_PRGA);
  assign accept     = idle_like && bus.start;
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  assign enter_init = (state_nxt == S_INIT) && (state != S_INIT);
  assign enter_ksa  = (state_nxt == S_KSA)  && (state != S_KSA);
  assign enter_prga = (state_nxt == S_PRGA) && (state != S_PRGA);

  rise_detect u_init_rise (
    .clk  (clk),
    .clr  (clr),
    .arm  (enter_init),
    .en   (state == S_INIT),
    .d    (bus.init_finished),
    .rise (init_rise)
  );

  rise_detect u_ksa_rise (
    .clk  (clk),
    .clr  (clr),
    .arm  (enter_ksa),
    .en   (state == S_KSA),
    .d    (bus.ksa_finished),
    .rise (ksa_rise)
  );

  rise_detect u_prga_rise (
    .clk  (clk),
    .clr  (clr),
    .arm  (enter_prga),
    .en   (state == S_PRGA),
    .d    (bus.prga_finished),
    .rise (prga_rise)
  );

  // Next phase: a finished edge beats a simultaneous watchdog expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_nxt = S_INIT;
      S_INIT: begin
        if (init_rise)       state_nxt = S_KSA;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_KSA: begin
        if (ksa_rise)        state_nxt = S_PRGA;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_PRGA: begin
        if (prga_rise)       state_nxt = S_DONE;
        else if (wd_expired) state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Watchdog: restarts on every phase change, counts busy cycles, saturates.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wd_cnt <= '0;
    end else if (state_nxt != state) begin
      wd_cnt <= '0;
    end else if (busy_w && (wd_cnt != '1)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Key is captured only when a run is accepted; busy-time starts leave it alone.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      key_r <= '0;
    end else if (accept) begin
      key_r <= bus.key;
    end
  end

  // Engine start pulses, high for the first cycle of their phase.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      init_start_r <= 1'b0;
      ksa_start_r  <= 1'b0;
      prga_start_r <= 1'b0;
    end else begin
      init_start_r <= enter_init;
      ksa_start_r  <= enter_ksa;
      prga_start_r <= enter_prga;
    end
  end

  // Memory port goes to the engine owning the current phase; parked otherwise.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    case (state)
      S_INIT: begin
        addr_mux  = bus.init_addr;
        wdata_mux = bus.init_wdata;
        we_mux    = bus.init_we;
      end
      S_KSA: begin
        addr_mux  = bus.ksa_addr;
        wdata_mux = bus.ksa_wdata;
        we_mux    = bus.ksa_we;
      end
      S_PRGA: begin
        addr_mux  = bus.prga_addr;
        wdata_mux = bus.prga_wdata;
        we_mux    = bus.prga_we;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.mem_we     = we_mux;
  assign bus.key_q      = key_r;
  assign bus.init_start = init_start_r;
  assign bus.ksa_start  = ksa_start_r;
  assign bus.prga_start = prga_start_r;
  assign bus.phase      = state;
  assign bus.busy       = busy_w;
  assign bus.done       = (state == S_DONE);
  assign bus.error      = (state == S_ERR);

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// tb/tb_rc4_phase_ctrl.sv - self-checking bench for rc4_phase_ctrl
module tb_rc4_phase_ctrl;
  import rc4_pkg::*;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [2:0] sel;
    int         cyc;
    logic [7:0] addr;
  } exp_t;

  exp_t exp_q[$];

  rc4_phase_ctrl_if #(.ADDR_W(8), .DATA_W(8), .KEY_W(24)) m_if ();
  rc4_phase_ctrl_if #(.ADDR_W(8), .DATA_W(8), .KEY_W(24)) w_if ();

  rc4_phase_ctrl #(.ADDR_W(8), .DATA_W(8), .KEY_W(24), .TIMEOUT(4096)) dut (
    .clk (clk),
    .clr (clr),
    .bus (m_if)
  );

  rc4_phase_ctrl #(.ADDR_W(8), .DATA_W(8), .KEY_W(24), .TIMEOUT(16)) dut_wd (
    .clk (clk),
    .clr (clr),
    .bus (w_if)
  );

  assign w_if.start         = m_if.start;
  assign w_if.key           = m_if.key;
  assign w_if.init_finished = m_if.init_finished;
  assign w_if.ksa_finished  = m_if.ksa_finished;
  assign w_if.prga_finished = m_if.prga_finished;
  assign w_if.init_addr     = m_if.init_addr;
  assign w_if.ksa_addr      = m_if.ksa_addr;
  assign w_if.prga_addr     = m_if.prga_addr;
  assign w_if.init_wdata    = m_if.init_wdata;
  assign w_if.ksa_wdata     = m_if.ksa_wdata;
  assign w_if.prga_wdata    = m_if.prga_wdata;
  assign w_if.init_we       = m_if.init_we;
  assign w_if.ksa_we        = m_if.ksa_we;
  assign w_if.prga_we       = m_if.prga_we;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to the next falling edge and score any start pulse of the main DUT.
  task automatic tick();
    logic [2:0] obs;
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_start: no pulse seen, required pulses=%b at cycle %0d", e.sel, e.cyc);
    end
    obs = {m_if.prga_start, m_if.ksa_start, m_if.init_start};
    if (obs != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: pulses=%b at cycle %0d, required none", obs, cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.sel || cyc != e.cyc || m_if.mem_addr !== e.addr) begin
          errors++;
          $display("FAIL start_pulse: pulses=%b cycle=%0d mem_addr=%h, required pulses=%b cycle=%0d mem_addr=%h",
                   obs, cyc, m_if.mem_addr, e.sel, e.cyc, e.addr);
        end
      end
    end
  endtask

  task automatic raise_fin(input int which);
    case (which)
      1: m_if.init_finished = 1'b1;
      2: m_if.ksa_finished  = 1'b1;
      default: m_if.prga_finished = 1'b1;
    endcase
    tick();
    case (which)
      1: m_if.init_finished = 1'b0;
      2: m_if.ksa_finished  = 1'b0;
      default: m_if.prga_finished = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    clr = 1'b1;
    m_if.start = 1'b0;
    m_if.key = 24'h0;
    m_if.init_finished = 1'b0;
    m_if.ksa_finished = 1'b0;
    m_if.prga_finished = 1'b0;
    m_if.init_addr = 8'h11;  m_if.init_wdata = 8'hA1;  m_if.init_we = 1'b1;
    m_if.ksa_addr  = 8'h22;  m_if.ksa_wdata  = 8'hA2;  m_if.ksa_we  = 1'b1;
    m_if.prga_addr = 8'h33;  m_if.prga_wdata = 8'hA3;  m_if.prga_we = 1'b1;
    tick();
    tick();
    checks++; if (m_if.phase !== 3'd0) begin errors++; $display("FAIL reset_phase: phase=%0d required 0", m_if.phase); end
    checks++; if ({m_if.busy, m_if.done, m_if.error} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/error=%b required 000", {m_if.busy, m_if.done, m_if.error}); end
    checks++; if ({m_if.init_start, m_if.ksa_start, m_if.prga_start} !== 3'b000) begin errors++; $display("FAIL reset_starts: starts=%b required 000", {m_if.init_start, m_if.ksa_start, m_if.prga_start}); end
    checks++; if (m_if.mem_we !== 1'b0 || m_if.mem_addr !== 8'h00 || m_if.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem: we=%b addr=%h wdata=%h required 0 00 00", m_if.mem_we, m_if.mem_addr, m_if.mem_wdata); end
    checks++; if (m_if.key_q !== 24'h0) begin errors++; $display("FAIL reset_key_q: key_q=%h required 000000", m_if.key_q); end
    clr = 1'b0;
    tick();
    checks++; if (m_if.phase !== 3'd0) begin errors++; $display("FAIL idle_hold: phase=%0d required 0", m_if.phase); end
  endtask

  task automatic test_normal_run();
    checks++; if (m_if.mem_we !== 1'b0 || m_if.mem_addr !== 8'h00) begin errors++; $display("FAIL idle_owner: we=%b addr=%h required 0 00", m_if.mem_we, m_if.mem_addr); end
    m_if.key = 24'h000249;
    m_if.start = 1'b1;
    exp_q.push_back('{3'b001, cyc + 1, 8'h11});
    tick();
    m_if.start = 1'b0;
    checks++; if (m_if.phase !== 3'd1 || m_if.busy !== 1'b1) begin errors++; $display("FAIL init_entry: phase=%0d busy=%b required 1 1", m_if.phase, m_if.busy); end
    checks++; if (m_if.mem_addr !== 8'h11 || m_if.mem_wdata !== 8'hA1 || m_if.mem_we !== 1'b1) begin errors++; $display("FAIL init_owner: addr=%h wdata=%h we=%b required 11 a1 1", m_if.mem_addr, m_if.mem_wdata, m_if.mem_we); end
    repeat (255) tick();
    exp_q.push_back('{3'b010, cyc + 1, 8'h22});
    raise_fin(1);
    checks++; if (m_if.phase !== 3'd2 || m_if.mem_addr !== 8'h22 || m_if.mem_wdata !== 8'hA2) begin errors++; $display("FAIL ksa_owner: phase=%0d addr=%h wdata=%h required 2 22 a2", m_if.phase, m_if.mem_addr, m_if.mem_wdata); end
    repeat (767) tick();
    exp_q.push_back('{3'b100, cyc + 1, 8'h33});
    raise_fin(2);
    checks++; if (m_if.phase !== 3'd3 || m_if.mem_addr !== 8'h33 || m_if.mem_wdata !== 8'hA3) begin errors++; $display("FAIL prga_owner: phase=%0d addr=%h wdata=%h required 3 33 a3", m_if.phase, m_if.mem_addr, m_if.mem_wdata); end
    repeat (95) tick();
    raise_fin(3);
    checks++; if (m_if.phase !== 3'd4 || m_if.done !== 1'b1 || m_if.busy !== 1'b0) begin errors++; $display("FAIL run_done: phase=%0d done=%b busy=%b required 4 1 0", m_if.phase, m_if.done, m_if.busy); end
    checks++; if (m_if.key_q !== 24'h000249) begin errors++; $display("FAIL run_key_q: key_q=%h required 000249", m_if.key_q); end
    checks++; if (m_if.mem_we !== 1'b0 || m_if.mem_addr !== 8'h00) begin errors++; $display("FAIL done_owner: we=%b addr=%h required 0 00", m_if.mem_we, m_if.mem_addr); end
  endtask

  task automatic test_stale_finished();
    m_if.init_finished = 1'b1;
    tick();
    tick();
    m_if.key = 24'h0000AA;
    m_if.start = 1'b1;
    exp_q.push_back('{3'b001, cyc + 1, 8'h11});
    tick();
    m_if.start = 1'b0;
    repeat (20) tick();
    checks++; if (m_if.phase !== 3'd1) begin errors++; $display("FAIL stale_level: phase=%0d required 1", m_if.phase); end
    m_if.init_finished = 1'b0;
    tick();
    checks++; if (m_if.phase !== 3'd1) begin errors++; $display("FAIL stale_fall: phase=%0d required 1", m_if.phase); end
    exp_q.push_back('{3'b010, cyc + 1, 8'h22});
    raise_fin(1);
    checks++; if (m_if.phase !== 3'd2) begin errors++; $display("FAIL stale_fresh_edge: phase=%0d required 2", m_if.phase); end
    tick();
    exp_q.push_back('{3'b100, cyc + 1, 8'h33});
    raise_fin(2);
    tick();
    raise_fin(3);
    checks++; if (m_if.phase !== 3'd4 || m_if.key_q !== 24'h0000AA) begin errors++; $display("FAIL stale_done: phase=%0d key_q=%h required 4 0000aa", m_if.phase, m_if.key_q); end
  endtask

  task automatic test_watchdog();
    m_if.key = 24'h13579B;
    m_if.start = 1'b1;
    exp_q.push_back('{3'b001, cyc + 1, 8'h11});
    tick();
    m_if.start = 1'b0;
    checks++; if (w_if.phase !== 3'd1) begin errors++; $display("FAIL wd_init: phase=%0d required 1", w_if.phase); end
    repeat (3) tick();
    exp_q.push_back('{3'b010, cyc + 1, 8'h22});
    raise_fin(1);
    checks++; if (w_if.phase !== 3'd2) begin errors++; $display("FAIL wd_ksa_entry: phase=%0d required 2", w_if.phase); end
    repeat (15) tick();
    checks++; if (w_if.phase !== 3'd2 || w_if.error !== 1'b0) begin errors++; $display("FAIL wd_early: phase=%0d error=%b required 2 0 at entry+15", w_if.phase, w_if.error); end
    tick();
    checks++; if (w_if.phase !== 3'd5 || w_if.error !== 1'b1 || w_if.busy !== 1'b0) begin errors++; $display("FAIL wd_expire: phase=%0d error=%b busy=%b required 5 1 0", w_if.phase, w_if.error, w_if.busy); end
    checks++; if (w_if.mem_we !== 1'b0 || w_if.mem_addr !== 8'h00) begin errors++; $display("FAIL wd_err_owner: we=%b addr=%h required 0 00", w_if.mem_we, w_if.mem_addr); end
    checks++; if (m_if.phase !== 3'd2) begin errors++; $display("FAIL wd_main_ksa: phase=%0d required 2", m_if.phase); end
    m_if.key = 24'h2468AC;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    checks++; if (w_if.phase !== 3'd1 || w_if.init_start !== 1'b1 || w_if.key_q !== 24'h2468AC) begin errors++; $display("FAIL wd_restart: phase=%0d init_start=%b key_q=%h required 1 1 2468ac", w_if.phase, w_if.init_start, w_if.key_q); end
    checks++; if (m_if.phase !== 3'd2 || m_if.key_q !== 24'h13579B) begin errors++; $display("FAIL busy_start_ksa: phase=%0d key_q=%h required 2 13579b", m_if.phase, m_if.key_q); end
  endtask

  task automatic test_busy_start_reset();
    exp_q.push_back('{3'b100, cyc + 1, 8'h33});
    raise_fin(2);
    checks++; if (m_if.phase !== 3'd3) begin errors++; $display("FAIL busy_prga_entry: phase=%0d required 3", m_if.phase); end
    m_if.key = 24'hABCDEF;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    checks++; if (m_if.phase !== 3'd3 || m_if.key_q !== 24'h13579B) begin errors++; $display("FAIL busy_start_prga: phase=%0d key_q=%h required 3 13579b", m_if.phase, m_if.key_q); end
    tick();
    raise_fin(3);
    checks++; if (m_if.phase !== 3'd4 || m_if.done !== 1'b1) begin errors++; $display("FAIL busy_done: phase=%0d done=%b required 4 1", m_if.phase, m_if.done); end
    m_if.key = 24'h0000FF;
    m_if.start = 1'b1;
    exp_q.push_back('{3'b001, cyc + 1, 8'h11});
    tick();
    m_if.start = 1'b0;
    tick();
    exp_q.push_back('{3'b010, cyc + 1, 8'h22});
    raise_fin(1);
    checks++; if (m_if.phase !== 3'd2) begin errors++; $display("FAIL clr_ksa_entry: phase=%0d required 2", m_if.phase); end
    tick();
    tick();
    clr = 1'b1;
    #1;
    checks++; if (m_if.phase !== 3'd0 || m_if.busy !== 1'b0) begin errors++; $display("FAIL clr_phase: phase=%0d busy=%b required 0 0", m_if.phase, m_if.busy); end
    checks++; if (m_if.mem_we !== 1'b0 || m_if.mem_addr !== 8'h00 || m_if.ksa_start !== 1'b0) begin errors++; $display("FAIL clr_mem: we=%b addr=%h ksa_start=%b required 0 00 0", m_if.mem_we, m_if.mem_addr, m_if.ksa_start); end
    checks++; if (m_if.key_q !== 24'h0) begin errors++; $display("FAIL clr_key_q: key_q=%h required 000000", m_if.key_q); end
    tick();
    clr = 1'b0;
    tick();
    checks++; if (m_if.phase !== 3'd0) begin errors++; $display("FAIL clr_release: phase=%0d required 0", m_if.phase); end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_stale_finished();
    test_watchdog();
    test_busy_start_reset();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_starts: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
